// File: rtl/demux_pkg.sv
// Shared types and default sizing for the 1:2 lane demultiplexer.
package demux_pkg;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    localparam int unsigned DEF_DATA_W = 2;
    localparam int unsigned DEF_DEPTH  = 4;

endpackage

// File: rtl/lane_fifo.sv
// Show-ahead lane FIFO: storage, wrapping pointers, occupancy count, full/empty,
// and a single-cycle underflow pulse when a pop is requested while empty.
module lane_fifo #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty;
    logic              do_pop;

    assign empty       = (count_q == '0);
    assign full_o      = (count_q == CNT_MAX);
    assign valid_o     = !empty;
    assign data_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop      = pop_i && !empty;
    assign underflow_o = pop_i && empty;

    // The caller gates push_i with !full_o, so no overflow guard is needed here.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/demux1_2_lanes.sv
// 1:2 demultiplexer into two independently drained lane FIFOs.
// Define DEMUX_ALTERNATE_EN to round-robin pushes instead of using selector.
module demux1_2_lanes
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              selector,
    output logic              ready_in,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out0,
    input  logic              pop0,
    output logic              valid_out1,
    output logic [DATA_W-1:0] data_out1,
    input  logic              pop1,
    output logic              err_underflow
);

    lane_e target;
    logic  full0, full1;
    logic  uf0, uf1;
    logic  accept;
    logic  err_q, err_d;

`ifdef DEMUX_ALTERNATE_EN
    logic alt_q, alt_d;

    assign target = lane_e'(alt_q);
    assign alt_d  = accept ? !alt_q : alt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alt_q <= 1'b0;
        end else begin
            alt_q <= alt_d;
        end
    end
`else
    assign target = lane_e'(selector);
`endif

    // Full is taken from registered occupancy only, so a same-cycle pop never admits a push.
    assign ready_in = (target == LANE1) ? !full1 : !full0;
    assign accept   = valid_in && ready_in;

    lane_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_lane0 (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept && (target == LANE0)),
        .data_i     (data_in),
        .pop_i      (pop0),
        .valid_o    (valid_out0),
        .data_o     (data_out0),
        .full_o     (full0),
        .underflow_o(uf0)
    );

    lane_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_lane1 (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept && (target == LANE1)),
        .data_i     (data_in),
        .pop_i      (pop1),
        .valid_o    (valid_out1),
        .data_o     (data_out1),
        .full_o     (full1),
        .underflow_o(uf1)
    );

    assign err_d         = err_q || uf0 || uf1;
    assign err_underflow = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_demux1_2_lanes.sv
// Scoreboard bench for demux1_2_lanes: a queue-based lane model tracks expected
// contents; a negedge monitor compares every DUT output against it.
module tb_demux1_2_lanes;

    localparam int unsigned DATA_W = 2;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              selector = 1'b0;
    logic              ready_in;
    logic              valid_out0, valid_out1;
    logic [DATA_W-1:0] data_out0, data_out1;
    logic              pop0 = 1'b0, pop1 = 1'b0;
    logic              err_underflow;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    logic              err_exp = 1'b0;
    logic              alt_exp = 1'b0;

    demux1_2_lanes #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .selector     (selector),
        .ready_in     (ready_in),
        .valid_out0   (valid_out0),
        .data_out0    (data_out0),
        .pop0         (pop0),
        .valid_out1   (valid_out1),
        .data_out1    (data_out1),
        .pop1         (pop1),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_target();
`ifdef DEMUX_ALTERNATE_EN
        return int'(alt_exp);
`else
        return int'(selector);
`endif
    endfunction

    // Reference model: two bounded queues, updated on each accepted push / legal pop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
            err_exp = 1'b0;
            alt_exp = 1'b0;
        end else begin
            int n0, n1, tgt;
            bit acc;
            n0  = exp_q0.size();
            n1  = exp_q1.size();
            tgt = model_target();
            acc = valid_in && ((tgt == 0) ? (n0 < DEPTH) : (n1 < DEPTH));
            if (pop0) begin
                if (n0 > 0) void'(exp_q0.pop_front());
                else err_exp = 1'b1;
            end
            if (pop1) begin
                if (n1 > 0) void'(exp_q1.pop_front());
                else err_exp = 1'b1;
            end
            if (acc) begin
                if (tgt == 0) exp_q0.push_back(data_in);
                else exp_q1.push_back(data_in);
                alt_exp = !alt_exp;
            end
        end
    end

    // Monitor: compare every visible output against the model between edges.
    always @(negedge clk) begin
        if (!reset) begin
            int tgt;
            tgt = model_target();
            chk("ready_in", 32'(ready_in),
                32'((tgt == 0) ? (exp_q0.size() < DEPTH) : (exp_q1.size() < DEPTH)));
            chk("valid_out0", 32'(valid_out0), 32'(exp_q0.size() > 0));
            chk("valid_out1", 32'(valid_out1), 32'(exp_q1.size() > 0));
            chk("data_out0", 32'(data_out0), 32'((exp_q0.size() > 0) ? exp_q0[0] : '0));
            chk("data_out1", 32'(data_out1), 32'((exp_q1.size() > 0) ? exp_q1[0] : '0));
            chk("err_underflow", 32'(err_underflow), 32'(err_exp));
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic s,
                       input logic p0, input logic p1);
        @(posedge clk);
        #1;
        valid_in = v;
        data_in  = d;
        selector = s;
        pop0     = p0;
        pop1     = p1;
    endtask

    task automatic idle_then_sample();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_valid_out0", 32'(valid_out0), 32'd0);
        chk("reset_data_out1", 32'(data_out1), 32'd0);
        chk("reset_err", 32'(err_underflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

`ifndef DEMUX_ALTERNATE_EN
        // Basic routing
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        idle_then_sample();
        chk("route_v0", 32'(valid_out0), 32'd1);
        chk("route_d0", 32'(data_out0), 32'h1);
        chk("route_v1", 32'(valid_out1), 32'd1);
        chk("route_d1", 32'(data_out1), 32'h2);
        do_reset();

        // Back-pressure on lane0
        for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_full_sel0", 32'(ready_in), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_other_lane", 32'(ready_in), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_same_cycle_pop", 32'(ready_in), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_after_pop", 32'(ready_in), 32'd1);
        do_reset();

        // Full lane with simultaneous push and pop: push rejected
        for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_pop_drained", 32'(valid_out0), 32'd0);
        chk("full_pop_no_uf", 32'(err_underflow), 32'd0);
        do_reset();

        // Wrap-around on lane1 with concurrent push/pop
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, DATA_W'(i % 4), 1'b1, 1'b0, (i > 0));
            @(negedge clk);
            chk("wrap_ready", 32'(ready_in), 32'd1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle_then_sample();
        chk("wrap_empty", 32'(valid_out1), 32'd0);

        // Underflow is sticky
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle_then_sample();
        chk("uf_set", 32'(err_underflow), 32'd1);
        repeat (3) idle_then_sample();
        chk("uf_sticky", 32'(err_underflow), 32'd1);

        // Async reset mid-stream with lane0 holding two words
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_v0", 32'(valid_out0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_v0", 32'(valid_out0), 32'd0);
        chk("arst_d0", 32'(data_out0), 32'd0);
        chk("arst_err", 32'(err_underflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_v0", 32'(valid_out0), 32'd0);
`else
        // Round-robin: selector held high must not steer
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        idle_then_sample();
        chk("alt_d0", 32'(data_out0), 32'h0);
        chk("alt_d1", 32'(data_out1), 32'h1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("alt_d0_2nd", 32'(data_out0), 32'h2);
        chk("alt_d1_2nd", 32'(data_out1), 32'h3);
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("alt_stall", 32'(ready_in), 32'd0);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("alt_no_skip", 32'(ready_in), 32'd0);
        cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("alt_resume", 32'(ready_in), 32'd1);
`endif
        do_reset();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
